bp_fe_bp_update_queue: RTL and testbench

- Bookkeeping stage directly upstream of the bimodal BHT write port.
- Records each prediction issued by the front end: BHT index plus predicted direction.
- On in-order branch resolution from the back end, pops the oldest record and drives a one-cycle update (valid, index, correct) into the predictor.
- Supports flushing wrong-path records.

---
 rtl/bp_fe_bp_pkg.sv | 11 +
 rtl/bp_fe_bp_rec_fifo.sv | 56 +++++
 rtl/bp_fe_bp_update_queue.sv | 89 ++++++++
 tb/tb_bp_fe_bp_update_queue.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_fe_bp_pkg.sv
// Shared branch-predictor types: BHT index width and the prediction record.
package bp_fe_bp_pkg;

  localparam int bht_idx_width = 8;

  typedef struct packed {
    logic [bht_idx_width-1:0] idx;
    logic                     taken;
  } bp_pred_rec_s;

endpackage

// File: rtl/bp_fe_bp_rec_fifo.sv
// Circular record FIFO with wrap-bit pointers and a flush that
// discards everything younger than the (post-resolve) head.
module bp_fe_bp_rec_fifo #(
  parameter int width_p = 9,
  parameter int els_p = 8,
  localparam int ptr_w = $clog2(els_p)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               enq_v_i,
  input  logic [width_p-1:0] enq_data_i,
  output logic               enq_ready_o,
  input  logic               deq_v_i,
  output logic               deq_ready_o,
  output logic               deq_fire_o,
  output logic [width_p-1:0] deq_data_o,
  input  logic               flush_i,
  output logic [ptr_w:0]     count_o
);

  logic [width_p-1:0] mem [els_p];
  logic [ptr_w:0] rptr, wptr;
  logic [ptr_w:0] rptr_next, wptr_next;
  logic full, empty, enq_fire;

  assign empty = (rptr == wptr);
  assign full  = (rptr[ptr_w-1:0] == wptr[ptr_w-1:0])
               & (rptr[ptr_w] != wptr[ptr_w]);

  assign enq_ready_o = ~full;
  assign deq_ready_o = ~empty;
  assign enq_fire    = enq_v_i & ~full & ~flush_i;
  assign deq_fire_o  = deq_v_i & ~empty;
  assign deq_data_o  = mem[rptr[ptr_w-1:0]];
  assign count_o     = wptr - rptr;

  // Flush collapses the tail onto the head left after any same-cycle pop.
  assign rptr_next = rptr + {{ptr_w{1'b0}}, deq_fire_o};
  assign wptr_next = flush_i ? rptr_next
                   : wptr + {{ptr_w{1'b0}}, enq_fire};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rptr <= '0;
      wptr <= '0;
    end else begin
      rptr <= rptr_next;
      wptr <= wptr_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq_fire) mem[wptr[ptr_w-1:0]] <= enq_data_i;
  end

endmodule

// File: rtl/bp_fe_bp_update_queue.sv
// Prediction bookkeeping queue feeding one-cycle BHT updates.
// Optional stats counters: BP_FE_BP_UPDATE_QUEUE_STATS_EN.
module bp_fe_bp_update_queue
  import bp_fe_bp_pkg::*;
#(
  parameter int bht_idx_width_p = bht_idx_width,
  parameter int queue_els_p = 8,
  localparam int ptr_width_lp = $clog2(queue_els_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       pred_v_i,
  input  logic [bht_idx_width_p-1:0] pred_idx_i,
  input  logic                       pred_taken_i,
  output logic                       pred_ready_o,
  input  logic                       res_v_i,
  input  logic                       res_taken_i,
  output logic                       res_ready_o,
  input  logic                       flush_i,
  output logic                       w_v_o,
  output logic [bht_idx_width_p-1:0] idx_w_o,
  output logic                       correct_o,
  output logic [ptr_width_lp:0]      count_o
`ifdef BP_FE_BP_UPDATE_QUEUE_STATS_EN
  ,
  output logic [31:0]                res_cnt_o,
  output logic [31:0]                mispredict_cnt_o
`endif
);

  typedef struct packed {
    logic [bht_idx_width_p-1:0] idx;
    logic                       taken;
  } rec_s;

  rec_s enq_rec, head;
  logic res_fire, hit;

  assign enq_rec = '{idx: pred_idx_i, taken: pred_taken_i};

  bp_fe_bp_rec_fifo #(
    .width_p($bits(rec_s)),
    .els_p  (queue_els_p)
  ) fifo (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .enq_v_i    (pred_v_i),
    .enq_data_i (enq_rec),
    .enq_ready_o(pred_ready_o),
    .deq_v_i    (res_v_i),
    .deq_ready_o(res_ready_o),
    .deq_fire_o (res_fire),
    .deq_data_o (head),
    .flush_i    (flush_i),
    .count_o    (count_o)
  );

  assign hit = (head.taken == res_taken_i);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      w_v_o     <= 1'b0;
      idx_w_o   <= '0;
      correct_o <= 1'b0;
    end else begin
      w_v_o <= res_fire;
      if (res_fire) begin
        idx_w_o   <= head.idx;
        correct_o <= hit;
      end
    end
  end

`ifdef BP_FE_BP_UPDATE_QUEUE_STATS_EN
  // Counted at the handshake so they line up with the emitted update.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      res_cnt_o        <= '0;
      mispredict_cnt_o <= '0;
    end else if (res_fire) begin
      if (res_cnt_o != '1)
        res_cnt_o <= res_cnt_o + 32'd1;
      if (!hit && mispredict_cnt_o != '1)
        mispredict_cnt_o <= mispredict_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_fe_bp_update_queue.sv
// Bench for bp_fe_bp_update_queue: vector table, directed corners,
// then random traffic against a queue-based reference model.
module tb_bp_fe_bp_update_queue;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic       pred_v_i;
  logic [7:0] pred_idx_i;
  logic       pred_taken_i;
  logic       pred_ready_o;
  logic       res_v_i;
  logic       res_taken_i;
  logic       res_ready_o;
  logic       flush_i;
  logic       w_v_o;
  logic [7:0] idx_w_o;
  logic       correct_o;
  logic [3:0] count_o;
`ifdef BP_FE_BP_UPDATE_QUEUE_STATS_EN
  logic [31:0] res_cnt_o;
  logic [31:0] mispredict_cnt_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  bp_fe_bp_update_queue dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .pred_v_i    (pred_v_i),
    .pred_idx_i  (pred_idx_i),
    .pred_taken_i(pred_taken_i),
    .pred_ready_o(pred_ready_o),
    .res_v_i     (res_v_i),
    .res_taken_i (res_taken_i),
    .res_ready_o (res_ready_o),
    .flush_i     (flush_i),
    .w_v_o       (w_v_o),
    .idx_w_o     (idx_w_o),
    .correct_o   (correct_o),
    .count_o     (count_o)
`ifdef BP_FE_BP_UPDATE_QUEUE_STATS_EN
    ,
    .res_cnt_o       (res_cnt_o),
    .mispredict_cnt_o(mispredict_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] idx;
    logic       taken;
  } rec_t;

  typedef struct {
    logic       pv;
    logic [7:0] pi;
    logic       pt;
    logic       rv;
    logic       rt;
    logic       fl;
    logic       ewv;
    logic [7:0] eidx;
    logic       ecorr;
    int         ecnt;
  } vec_t;

  // Reference model: an ordered list of outstanding predictions.
  rec_t       q[$];
  logic       m_wv;
  logic [7:0] m_idx;
  logic       m_corr;
  int         m_res;
  int         m_mis;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic pv, input logic [7:0] pi,
                       input logic pt, input logic rv,
                       input logic rt, input logic fl);
    pred_v_i     = pv;
    pred_idx_i   = pi;
    pred_taken_i = pt;
    res_v_i      = rv;
    res_taken_i  = rt;
    flush_i      = fl;
  endtask

  task automatic model_clear();
    q.delete();
    m_wv   = 1'b0;
    m_idx  = 8'h00;
    m_corr = 1'b0;
    m_res  = 0;
    m_mis  = 0;
  endtask

  // One cycle: check pointer-derived outputs, clock, update model, check.
  task automatic cyc(input logic pv, input logic [7:0] pi,
                     input logic pt, input logic rv,
                     input logic rt, input logic fl);
    int n;
    rec_t r;
    drive(pv, pi, pt, rv, rt, fl);
    n = q.size();
    chk("pred_ready", int'(pred_ready_o), int'(n < 8));
    chk("res_ready", int'(res_ready_o), int'(n > 0));
    chk("count_pre", int'(count_o), n);
    @(posedge clk_i);
    #1;
    m_wv = 1'b0;
    if (rv && n > 0) begin
      r = q.pop_front();
      m_wv   = 1'b1;
      m_idx  = r.idx;
      m_corr = (r.taken == rt);
      m_res++;
      if (!m_corr) m_mis++;
    end
    if (fl) q.delete();
    else if (pv && n < 8) q.push_back('{idx: pi, taken: pt});
    chk("w_v", int'(w_v_o), int'(m_wv));
    chk("idx_w", int'(idx_w_o), int'(m_idx));
    chk("correct", int'(correct_o), int'(m_corr));
    chk("count", int'(count_o), q.size());
    drive(0, 8'h00, 0, 0, 0, 0);
  endtask

  // Asynchronous reset assertion: outputs must clear without a clock.
  task automatic do_reset();
    reset_n_i = 1'b0;
    #1;
    chk("rst_w_v", int'(w_v_o), 0);
    chk("rst_idx_w", int'(idx_w_o), 0);
    chk("rst_correct", int'(correct_o), 0);
    chk("rst_count", int'(count_o), 0);
    chk("rst_pred_ready", int'(pred_ready_o), 1);
    chk("rst_res_ready", int'(res_ready_o), 0);
    model_clear();
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
  endtask

  vec_t tbl[8];

  initial begin
    reset_n_i = 1'b0;
    drive(0, 8'h00, 0, 0, 0, 0);
    model_clear();
    #2;
    chk("init_w_v", int'(w_v_o), 0);
    chk("init_count", int'(count_o), 0);
    chk("init_pred_ready", int'(pred_ready_o), 1);
    chk("init_res_ready", int'(res_ready_o), 0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;

    // pv pi pt rv rt fl | wv idx corr count
    tbl[0] = '{1, 8'h12, 1, 0, 0, 0, 0, 8'h00, 0, 1};
    tbl[1] = '{0, 8'h00, 0, 1, 1, 0, 1, 8'h12, 1, 0};
    tbl[2] = '{0, 8'h00, 0, 0, 0, 0, 0, 8'h12, 1, 0};
    tbl[3] = '{1, 8'h34, 0, 0, 0, 0, 0, 8'h12, 1, 1};
    tbl[4] = '{1, 8'h56, 1, 0, 0, 0, 0, 8'h12, 1, 2};
    tbl[5] = '{1, 8'h78, 0, 1, 1, 0, 1, 8'h34, 0, 2};
    tbl[6] = '{1, 8'h9a, 0, 1, 1, 1, 1, 8'h56, 1, 0};
    tbl[7] = '{0, 8'h00, 0, 1, 0, 0, 0, 8'h56, 1, 0};
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].pv, tbl[i].pi, tbl[i].pt,
            tbl[i].rv, tbl[i].rt, tbl[i].fl);
      @(posedge clk_i);
      #1;
      chk($sformatf("tbl%0d_w_v", i), int'(w_v_o), int'(tbl[i].ewv));
      chk($sformatf("tbl%0d_idx", i), int'(idx_w_o), int'(tbl[i].eidx));
      chk($sformatf("tbl%0d_corr", i), int'(correct_o),
          int'(tbl[i].ecorr));
      chk($sformatf("tbl%0d_cnt", i), int'(count_o), tbl[i].ecnt);
    end
    drive(0, 8'h00, 0, 0, 0, 0);

    do_reset();

    // Fill to full with alternating taken, then full-queue corners.
    for (int i = 0; i < 8; i++)
      cyc(1, 8'(i), i[0] ? 1'b1 : 1'b0, 0, 0, 0);
    chk("full_pred_ready", int'(pred_ready_o), 0);
    chk("full_count", int'(count_o), 8);
    cyc(1, 8'hAA, 1, 1, 0, 0);
    chk("full_both_count", int'(count_o), 7);
    cyc(1, 8'hBB, 0, 1, 0, 0);
    chk("seven_both_count", int'(count_o), 7);
    while (q.size() > 0) cyc(0, 8'h00, 0, 1, 0, 0);
    cyc(0, 8'h00, 0, 0, 0, 0);

    // Flush with a same-cycle mispredicted resolve.
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'h40 + i), 0, 0, 0, 0);
    cyc(0, 8'h00, 0, 1, 1, 1);
    chk("flush_correct", int'(correct_o), 0);
    chk("flush_res_ready", int'(res_ready_o), 0);
    cyc(0, 8'h00, 0, 0, 0, 1);
    cyc(0, 8'h00, 0, 1, 0, 0);

    // Pointer wrap: 20 enqueue/resolve pairs.
    for (int i = 0; i < 20; i++) begin
      cyc(1, 8'(8'hC0 + i), i[1] ? 1'b1 : 1'b0, 0, 0, 0);
      cyc(0, 8'h00, 0, 1, 1, 0);
    end

    // Reset mid-stream with an update just registered.
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'h20 + i), 1, 0, 0, 0);
    cyc(0, 8'h00, 0, 1, 1, 0);
    do_reset();
    cyc(0, 8'h00, 0, 1, 1, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
    end

`ifdef BP_FE_BP_UPDATE_QUEUE_STATS_EN
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 8'(i), 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 8'h00, 0, 1, i < 3, 0);
    chk("res_cnt", int'(res_cnt_o), m_res);
    chk("mispredict_cnt", int'(mispredict_cnt_o), m_mis);
    chk("res_cnt_5", int'(res_cnt_o), 5);
    chk("mispredict_cnt_2", int'(mispredict_cnt_o), 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
